// File: rtl/key_led_pkg.sv
// Shared constants for the key-driven LED mode controller: mode encoding,
// LED width, and helpers for mode sequencing and mode-entry LED patterns.
package key_led_pkg;

    localparam int LED_W = 4;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_RUN   = 2'd3
    } mode_e;

    // Mode sequence: OFF -> ON -> BLINK -> RUN -> OFF
    function automatic mode_e next_mode(input mode_e m);
        mode_e r;
        case (m)
            MODE_OFF:   r = MODE_ON;
            MODE_ON:    r = MODE_BLINK;
            MODE_BLINK: r = MODE_RUN;
            default:    r = MODE_OFF;
        endcase
        return r;
    endfunction

    // LED pattern loaded when a mode is entered
    function automatic logic [LED_W-1:0] entry_led(input mode_e m);
        logic [LED_W-1:0] r;
        case (m)
            MODE_ON:    r = {LED_W{1'b1}};
            MODE_BLINK: r = {LED_W{1'b1}};
            MODE_RUN:   r = {{(LED_W-1){1'b0}}, 1'b1};
            default:    r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/key_edge_det.sv
// Falling-edge press detector for one debounced, active-low key.
// The key is sampled into two stages; a press is stage0 low with stage1 high.
// The armed flag stays low after reset until the key has been sampled high,
// so a key already held down when reset is released never reads as a press.
module key_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);

    logic stage0_q;
    logic stage1_q;
    logic armed_q;

    // Sample the key and remember whether it has been seen released since reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage0_q <= 1'b1;
            stage1_q <= 1'b1;
            armed_q  <= 1'b0;
        end else begin
            stage0_q <= key_n;
            stage1_q <= stage0_q;
            armed_q  <= armed_q | key_n;
        end
    end

    assign press = armed_q && !stage0_q && stage1_q;

endmodule

// File: rtl/led_mode_ctrl.sv
// Key-driven LED pattern controller: mode key cycles OFF/ON/BLINK/RUN, speed
// key selects step period TICK_DIV >> speed, pause key freezes the pattern.
// TICK_DIV must be at least 8 so every speed setting has a period >= 1.
module led_mode_ctrl
    import key_led_pkg::*;
#(
    parameter int TICK_DIV = 25_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_mode,
    input  logic             key_speed,
    input  logic             key_pause,
    output logic [LED_W-1:0] led,
    output logic [1:0]       mode,
    output logic [1:0]       speed,
    output logic             paused
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam int N_KEY = 3;

    logic [N_KEY-1:0] keys_n;
    logic [N_KEY-1:0] press;

    mode_e            mode_q;
    mode_e            mode_d;
    logic [1:0]       speed_q;
    logic             paused_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] last_cnt;
    logic [LED_W-1:0] led_q;

    logic mode_press;
    logic speed_press;
    logic pause_press;
    logic cnt_clear;
    logic step;

    assign keys_n = {key_pause, key_speed, key_mode};

    generate
        for (genvar gi = 0; gi < N_KEY; gi++) begin : g_key
            key_edge_det u_key_edge_det (
                .clk   (clk),
                .rst_n (rst_n),
                .key_n (keys_n[gi]),
                .press (press[gi])
            );
        end
    endgenerate

    assign mode_press  = press[0];
    assign speed_press = press[1];
    assign pause_press = press[2];

    // A mode or speed press restarts the period, so the new timing applies at once
    assign cnt_clear = mode_press | speed_press;
    assign last_cnt  = CNT_W'((TICK_DIV >> speed_q) - 1);
    assign step      = !paused_q && !cnt_clear && (cnt_q == last_cnt);
    assign cnt_d     = (cnt_q == last_cnt) ? '0 : cnt_q + CNT_W'(1);
    assign mode_d    = next_mode(mode_q);

    // Mode FSM with speed index, pause flag, step counter and LED pattern
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q   <= MODE_OFF;
            speed_q  <= 2'd0;
            paused_q <= 1'b0;
            cnt_q    <= '0;
            led_q    <= '0;
        end else begin
            if (mode_press) begin
                mode_q <= mode_d;
                led_q  <= entry_led(mode_d);
            end else if (step) begin
                case (mode_q)
                    MODE_BLINK: led_q <= ~led_q;
                    MODE_RUN:   led_q <= {led_q[LED_W-2:0], led_q[LED_W-1]};
                    default:    led_q <= led_q;
                endcase
            end

            if (speed_press) begin
                speed_q <= speed_q + 2'd1;
            end

            // A mode change always leaves the controller running
            if (mode_press) begin
                paused_q <= 1'b0;
            end else if (pause_press) begin
                paused_q <= !paused_q;
            end

            if (cnt_clear) begin
                cnt_q <= '0;
            end else if (!paused_q) begin
                cnt_q <= cnt_d;
            end
        end
    end

    assign led    = led_q;
    assign mode   = mode_q;
    assign speed  = speed_q;
    assign paused = paused_q;

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Directed bench for led_mode_ctrl with TICK_DIV = 16: reset, press timing,
// RUN/BLINK stepping, speed changes, pause/resume and simultaneous presses.
module tb_led_mode_ctrl;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       key_mode  = 1'b1;
    logic       key_speed = 1'b1;
    logic       key_pause = 1'b1;
    logic [3:0] led;
    logic [1:0] mode;
    logic [1:0] speed;
    logic       paused;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    led_mode_ctrl #(.TICK_DIV(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_mode  (key_mode),
        .key_speed (key_speed),
        .key_pause (key_pause),
        .led       (led),
        .mode      (mode),
        .speed     (speed),
        .paused    (paused)
    );

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %-14s got=%0h exp=%0h  t=%0t", tag, got, exp, $time);
        end else begin
            $display("ok   %-14s val=%0h  t=%0t", tag, got, $time);
        end
    endtask

    // Advance n rising edges, then settle 1 ns past the last one
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Hold the selected keys low so the press registers on the second edge;
    // returns 1 ns after that edge with the keys released
    task automatic press_keys(input logic m, input logic s, input logic p);
        if (m) key_mode  = 1'b0;
        if (s) key_speed = 1'b0;
        if (p) key_pause = 1'b0;
        tick(2);
        key_mode  = 1'b1;
        key_speed = 1'b1;
        key_pause = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state, before any clock edge
        #2;
        check_val("rst_led", {4'd0, led}, 8'h00);
        check_val("rst_mode", {6'd0, mode}, 8'h00);
        check_val("rst_speed", {6'd0, speed}, 8'h00);
        check_val("rst_paused", {7'd0, paused}, 8'h00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tick(2);
        check_val("idle_mode", {6'd0, mode}, 8'h00);

        // Single press held for 10 clocks: change on second edge, once only
        key_mode = 1'b0;
        tick(1);
        check_val("press_e1", {6'd0, mode}, 8'h00);
        tick(1);
        check_val("press_e2", {6'd0, mode}, 8'h01);
        check_val("on_led", {4'd0, led}, 8'h0f);
        tick(8);
        check_val("held_mode", {6'd0, mode}, 8'h01);
        key_mode = 1'b1;
        tick(1);

        // BLINK, then RUN stepping at speed 0 (16 clocks per step)
        press_keys(1'b1, 1'b0, 1'b0);
        check_val("blink_mode", {6'd0, mode}, 8'h02);
        check_val("blink_led", {4'd0, led}, 8'h0f);
        tick(1);
        press_keys(1'b1, 1'b0, 1'b0);
        check_val("run_mode", {6'd0, mode}, 8'h03);
        check_val("run_entry", {4'd0, led}, 8'h01);
        tick(15);
        check_val("run_15", {4'd0, led}, 8'h01);
        tick(1);
        check_val("run_16", {4'd0, led}, 8'h02);
        tick(48);
        check_val("run_64", {4'd0, led}, 8'h01);

        // Pause at led=0100 with 7 counts done; resume needs 9 more edges
        tick(16);
        check_val("run_80", {4'd0, led}, 8'h02);
        tick(16);
        check_val("run_96", {4'd0, led}, 8'h04);
        tick(5);
        press_keys(1'b0, 1'b0, 1'b1);
        check_val("pause_on", {7'd0, paused}, 8'h01);
        tick(100);
        check_val("pause_hold", {4'd0, led}, 8'h04);
        press_keys(1'b0, 1'b0, 1'b1);
        check_val("pause_off", {7'd0, paused}, 8'h00);
        tick(8);
        check_val("resume_8", {4'd0, led}, 8'h04);
        tick(1);
        check_val("resume_9", {4'd0, led}, 8'h08);

        // Back round to BLINK
        tick(1);
        press_keys(1'b1, 1'b0, 1'b0);
        check_val("off_mode", {6'd0, mode}, 8'h00);
        check_val("off_led", {4'd0, led}, 8'h00);
        tick(1);
        press_keys(1'b1, 1'b0, 1'b0);
        check_val("on2_led", {4'd0, led}, 8'h0f);
        tick(1);
        press_keys(1'b1, 1'b0, 1'b0);
        check_val("blink2_mode", {6'd0, mode}, 8'h02);

        // Speed 2: invert every 4 clocks
        press_keys(1'b0, 1'b1, 1'b0);
        check_val("speed_1", {6'd0, speed}, 8'h01);
        tick(1);
        press_keys(1'b0, 1'b1, 1'b0);
        check_val("speed_2", {6'd0, speed}, 8'h02);
        check_val("sp2_led0", {4'd0, led}, 8'h0f);
        tick(3);
        check_val("sp2_led3", {4'd0, led}, 8'h0f);
        tick(1);
        check_val("sp2_led4", {4'd0, led}, 8'h00);
        tick(4);
        check_val("sp2_led8", {4'd0, led}, 8'h0f);

        // Speed 3: invert every 2 clocks
        press_keys(1'b0, 1'b1, 1'b0);
        check_val("speed_3", {6'd0, speed}, 8'h03);
        tick(1);
        check_val("sp3_led1", {4'd0, led}, 8'h0f);
        tick(1);
        check_val("sp3_led2", {4'd0, led}, 8'h00);
        tick(1);

        // Speed wraps to 0: back to 16 clocks
        press_keys(1'b0, 1'b1, 1'b0);
        check_val("speed_wrap", {6'd0, speed}, 8'h00);
        check_val("sp0_led0", {4'd0, led}, 8'h0f);
        tick(15);
        check_val("sp0_led15", {4'd0, led}, 8'h0f);
        tick(1);
        check_val("sp0_led16", {4'd0, led}, 8'h00);

        // Paused in BLINK, then mode and pause pressed together
        press_keys(1'b0, 1'b0, 1'b1);
        check_val("blink_pause", {7'd0, paused}, 8'h01);
        tick(3);
        check_val("blink_hold", {4'd0, led}, 8'h00);
        press_keys(1'b1, 1'b0, 1'b1);
        check_val("sim_mode", {6'd0, mode}, 8'h03);
        check_val("sim_paused", {7'd0, paused}, 8'h00);
        check_val("sim_led", {4'd0, led}, 8'h01);
        tick(15);
        check_val("sim_led15", {4'd0, led}, 8'h01);
        tick(1);
        check_val("sim_led16", {4'd0, led}, 8'h02);

        // Mode and speed pressed together
        tick(1);
        press_keys(1'b1, 1'b1, 1'b0);
        check_val("ms_mode", {6'd0, mode}, 8'h00);
        check_val("ms_speed", {6'd0, speed}, 8'h01);
        check_val("ms_led", {4'd0, led}, 8'h00);

        // Reset asserted mid-RUN while paused, released with key_mode held
        tick(1);
        press_keys(1'b1, 1'b0, 1'b0);
        tick(1);
        press_keys(1'b1, 1'b0, 1'b0);
        tick(1);
        press_keys(1'b1, 1'b0, 1'b0);
        check_val("pre_rst_mode", {6'd0, mode}, 8'h03);
        tick(1);
        press_keys(1'b0, 1'b0, 1'b1);
        check_val("pre_rst_pause", {7'd0, paused}, 8'h01);
        tick(5);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_led", {4'd0, led}, 8'h00);
        check_val("mid_rst_mode", {6'd0, mode}, 8'h00);
        check_val("mid_rst_speed", {6'd0, speed}, 8'h00);
        check_val("mid_rst_pause", {7'd0, paused}, 8'h00);
        key_mode = 1'b0;
        tick(2);
        @(negedge clk);
        rst_n = 1'b1;
        tick(4);
        check_val("held_rel_mode", {6'd0, mode}, 8'h00);
        check_val("held_rel_led", {4'd0, led}, 8'h00);
        key_mode = 1'b1;
        tick(1);
        press_keys(1'b1, 1'b0, 1'b0);
        check_val("first_press", {6'd0, mode}, 8'h01);
        check_val("first_led", {4'd0, led}, 8'h0f);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
